// File: rtl/viterbi_pkg.sv
// Shared definitions for the Viterbi link.
// The encoder, the decoder and the branch-metric units all use these
// code parameters, so the code polynomials can never diverge.
//   K   constraint length
//   G0  generator for symbol bit 0 (MSB taps the current bit)
//   G1  generator for symbol bit 1 (same tap convention)
package viterbi_pkg;

  localparam int             K  = 3;
  localparam logic [K-1:0]   G0 = 3'b111;
  localparam logic [K-1:0]   G1 = 3'b101;

  typedef enum logic {
    S_DATA,
    S_FLUSH
  } enc_state_t;

  typedef logic [1:0] sym_t;

endpackage

// File: rtl/conv_parity.sv
// Parity of one generator tap set over the encoder window.
// Ports:
//   w       in  K  window {u(t), u(t-1), ..., u(t-K+1)}
//   gen     in  K  generator polynomial, MSB taps u(t)
//   parity  out 1  XOR of the tapped window bits
module conv_parity #(
  parameter int K = 3
) (
  input  logic [K-1:0] w,
  input  logic [K-1:0] gen,
  output logic         parity
);

  assign parity = ^(w & gen);

endmodule

// File: rtl/conv_encoder.sv
// Rate-1/2 convolutional encoder with zero-tail termination.
// One information bit per accepted handshake yields one registered symbol;
// after the frame's last bit, K-1 zero tail bits drive the trellis to state 0.
// Ports:
//   clk        in  1  clock, rising edge
//   rst_n      in  1  asynchronous active-low reset
//   in_bit     in  1  information bit
//   in_valid   in  1  in_bit is valid
//   in_last    in  1  in_bit is the final bit of the frame
//   in_ready   out 1  encoder accepts in_bit this cycle
//   tx_pair    out 2  encoded symbol {p1, p0}
//   out_valid  out 1  tx_pair is valid
//   out_last   out 1  tx_pair is the final tail symbol of the frame
//   out_ready  in  1  downstream accepts tx_pair this cycle
module conv_encoder #(
  parameter int           K  = viterbi_pkg::K,
  parameter logic [K-1:0] G0 = viterbi_pkg::G0,
  parameter logic [K-1:0] G1 = viterbi_pkg::G1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_bit,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [1:0] tx_pair,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready
);

  import viterbi_pkg::*;

  localparam int            TW        = $clog2(K);
  localparam logic [TW-1:0] LAST_TAIL = TW'(K - 2);

  enc_state_t    state;
  logic [K-2:0]  sr;        // sr[K-2] = u(t-1), sr[0] = u(t-K+1)
  logic [TW-1:0] tail_cnt;

  logic          load;
  logic          step;
  logic          u;
  logic [K-1:0]  w;
  logic          p0;
  logic          p1;
  sym_t          next_sym;

  // The output register can take a new symbol when empty or being drained.
  assign load     = !out_valid || out_ready;
  assign in_ready = (state == S_DATA) && load;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    u    = 1'b0;
    step = load;
    if (state == S_DATA) begin
      u    = in_bit;
      step = in_valid && load;
    end
  end

  assign w        = {u, sr};
  assign next_sym = {p1, p0};

  conv_parity #(.K(K)) u_parity0 (.w(w), .gen(G0), .parity(p0));
  conv_parity #(.K(K)) u_parity1 (.w(w), .gen(G1), .parity(p1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_DATA;
      sr        <= '0;
      tail_cnt  <= '0;
      tx_pair   <= 2'b00;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (step) begin
      // Shifting {u, sr} right by one drops the oldest bit.
      sr        <= w[K-1:1];
      tx_pair   <= next_sym;
      out_valid <= 1'b1;
      out_last  <= 1'b0;
      case (state)
        S_DATA: begin
          if (in_last) begin
            state    <= S_FLUSH;
            tail_cnt <= '0;
          end
        end
        S_FLUSH: begin
          tail_cnt <= tail_cnt + 1'b1;
          // The (K-1)th tail symbol closes the frame; sr is all zero after it.
          if (tail_cnt == LAST_TAIL) begin
            out_last <= 1'b1;
            state    <= S_DATA;
          end
        end
        default: state <= S_DATA;
      endcase
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_encoder.sv
// Self-checking bench for conv_encoder: directed frames with literal symbol
// lists plus randomized frames and stalls against a reference model that
// encodes each frame from its bit history.
module tb_conv_encoder;
  import viterbi_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_bit = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready;
  logic [1:0] tx_pair;
  logic       out_valid;
  logic       out_last;

  always #5 clk = ~clk;

  conv_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .tx_pair   (tx_pair),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state.
  int         frame_bits[$];   // frame bits so far, tail zeros included
  bit         m_valid;
  bit         m_last;
  logic [1:0] m_pair;
  int         tail_left;       // tail symbols still to be loaded
  int         frame_len;
  int         rx_count;        // symbols delivered in the current frame
  int         rx_syms[$];      // every symbol delivered, for directed checks
  int         cyc;

  // Symbol for the newest bit of the history, straight from the generator
  // polynomials: bits before the frame start count as zero.
  function automatic logic [1:0] ref_sym(input int bits[$]);
    int   t;
    int   b;
    logic q0;
    logic q1;
    t  = bits.size() - 1;
    q0 = 1'b0;
    q1 = 1'b0;
    for (int j = 0; j < K; j++) begin
      b  = (t - j >= 0) ? bits[t - j] : 0;
      q0 = q0 ^ (G0[K-1-j] & b[0]);
      q1 = q1 ^ (G1[K-1-j] & b[0]);
    end
    return {q1, q0};
  endfunction

  task automatic model_reset();
    frame_bits.delete();
    m_valid   = 1'b0;
    m_last    = 1'b0;
    m_pair    = 2'b00;
    tail_left = 0;
    frame_len = 0;
    rx_count  = 0;
  endtask

  // One clock cycle: drive at negedge, check, then advance the model to
  // match the coming rising edge. mode: 0 ready, 1 pattern 1,0,0,1, 2 random.
  task automatic step(input logic iv, input logic ib, input logic il,
                      input int mode, output bit acc);
    logic orr;
    bit   load;
    @(negedge clk);
    case (mode)
      0:       orr = 1'b1;
      1:       orr = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: orr = ($urandom_range(0, 99) >= 25);
    endcase
    cyc++;
    in_valid  = iv;
    in_bit    = ib;
    in_last   = il;
    out_ready = orr;
    #1;
    load = !m_valid || orr;
    check("out_valid", out_valid, m_valid);
    if (m_valid) begin
      check("tx_pair", tx_pair, m_pair);
      check("out_last", out_last, m_last);
    end
    check("in_ready", in_ready, (tail_left == 0) && load);

    if (m_valid && orr) begin
      rx_syms.push_back(int'(m_pair));
      rx_count++;
      if (m_last) begin
        check("frame_symbols", rx_count, frame_len + K - 1);
        rx_count = 0;
      end
    end

    acc = 1'b0;
    if (tail_left == 0) begin
      if (iv && load) begin
        frame_bits.push_back(int'(ib));
        m_pair  = ref_sym(frame_bits);
        m_valid = 1'b1;
        m_last  = 1'b0;
        acc     = 1'b1;
        if (il) begin
          tail_left = K - 1;
          frame_len = frame_bits.size();
        end
      end else if (orr) begin
        m_valid = 1'b0;
        m_last  = 1'b0;
      end
    end else if (load) begin
      frame_bits.push_back(0);
      m_pair  = ref_sym(frame_bits);
      m_valid = 1'b1;
      tail_left--;
      m_last  = (tail_left == 0);
      if (tail_left == 0) frame_bits.delete();
    end
  endtask

  task automatic send_frame(input int bits[$], input int mode);
    int idx;
    int guard;
    bit acc;
    idx   = 0;
    guard = 0;
    while (idx < bits.size() && guard < 2000) begin
      step(1'b1, bits[idx][0], idx == bits.size() - 1, mode, acc);
      if (acc) idx++;
      guard++;
    end
    check("frame_accepted", idx, bits.size());
  endtask

  task automatic drain(input int mode);
    int guard;
    bit acc;
    guard = 0;
    while ((m_valid || tail_left != 0) && guard < 2000) begin
      step(1'b0, 1'b0, 1'b0, mode, acc);
      guard++;
    end
    @(negedge clk);
    #1;
    check("drained", out_valid, 1'b0);
  endtask

  task automatic expect_syms(input string tag, input int exp[$]);
    check({tag, "_count"}, rx_syms.size(), exp.size());
    for (int i = 0; i < exp.size() && i < rx_syms.size(); i++)
      check(tag, rx_syms[i], exp[i]);
    rx_syms.delete();
  endtask

  initial begin
    int q[$];
    int e[$];
    int len;
    bit acc;

    model_reset();
    cyc = 0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_tx_pair", tx_pair, 2'b00);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1'b1);

    // Basic frame.
    q = {1, 0, 1, 1};
    e = {3, 1, 0, 2, 2, 3};
    send_frame(q, 0);
    drain(0);
    expect_syms("basic", e);

    // Same frame under the 1,0,0,1 backpressure pattern.
    cyc = 0;
    send_frame(q, 1);
    drain(1);
    expect_syms("backpressure", e);

    // One-bit frame.
    q = {1};
    e = {3, 1, 3};
    send_frame(q, 0);
    drain(0);
    expect_syms("one_bit", e);

    // Back-to-back frames with in_valid held high.
    q = {1, 0};
    send_frame(q, 0);
    q = {1};
    send_frame(q, 0);
    drain(0);
    e = {3, 1, 3, 0, 3, 1, 3};
    expect_syms("back_to_back", e);

    // Reset during the 2nd tail cycle.
    q = {1, 0};
    send_frame(q, 0);
    step(1'b0, 1'b0, 1'b0, 0, acc);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_last", out_last, 1'b0);
    check("midrst_tx_pair", tx_pair, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    check("midrst_in_ready", in_ready, 1'b1);
    rx_syms.delete();
    q = {1};
    e = {3, 1, 3};
    send_frame(q, 0);
    drain(0);
    expect_syms("after_reset", e);

    // Randomized frames with random stalls.
    for (int f = 0; f < 1000; f++) begin
      q.delete();
      len = $urandom_range(1, 64);
      for (int i = 0; i < len; i++) q.push_back(int'($urandom_range(0, 1)));
      send_frame(q, 2);
    end
    drain(2);
    rx_syms.delete();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
